kv_store: RTL and testbench

Parametrised associative key/value store with a Wishbone-style slave handshake. It supports four operations: lookup by key, reverse lookup by value, insert/update, and delete. Each operation runs a sequential scan of the table, one entry per cycle, then a single response cycle. It is the generalised successor of the fixed 7-bit/8-entry key/value block: widths and depth are parametrised, and it adds valid tracking, delete, occupancy count and full/miss reporting.

---
 rtl/kv_store.sv | 257 +++++++++++++++++++++++++
 tb/tb_kv_store.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kv_store.sv
// kv_store: parametrised associative key/value store behind a Wishbone-style
// slave handshake. A request runs a linear scan of the table, one entry per
// clock, followed by one response cycle that applies any table update and
// registers every result output.
//
// Ports
//   sys_clk   clock, rising edge
//   sys_rst   asynchronous active-high reset; clears state, table and outputs
//   CYC_i     bus cycle valid; dropping it during a scan aborts the request
//   STB_i     strobe; request accepted when CYC_i & STB_i are high while idle
//   OP_i      0 lookup by key, 1 reverse lookup by value, 2 insert/update, 3 delete
//   KEY_i     request key
//   VAL_i     request value
//   ACK_o     one-cycle response strobe
//   STALL_o   busy (not idle)
//   HIT_o     matching valid entry found
//   DUP_o     insert overwrote an existing key
//   FULL_o    every entry valid
//   ERR_o     insert rejected, table full
//   KEY_o     key of matched / written entry
//   VAL_o     value of matched / written entry
//   COUNT_o   number of valid entries
module kv_store #(
  parameter int KEY_W = 7,
  parameter int VAL_W = 7,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             CYC_i,
  input  logic             STB_i,
  input  logic [1:0]       OP_i,
  input  logic [KEY_W-1:0] KEY_i,
  input  logic [VAL_W-1:0] VAL_i,
  output logic             ACK_o,
  output logic             STALL_o,
  output logic             HIT_o,
  output logic             DUP_o,
  output logic             FULL_o,
  output logic             ERR_o,
  output logic [KEY_W-1:0] KEY_o,
  output logic [VAL_W-1:0] VAL_o,
  output logic [CW-1:0]    COUNT_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             mfound_q, mfound_d;
  logic             ffound_q, ffound_d;
  logic [IW-1:0]    midx_q, midx_d;
  logic [IW-1:0]    fidx_q, fidx_d;

  logic             tbl_vld_q [DEPTH];
  logic             tbl_vld_d [DEPTH];
  logic [KEY_W-1:0] tbl_key_q [DEPTH];
  logic [KEY_W-1:0] tbl_key_d [DEPTH];
  logic [VAL_W-1:0] tbl_val_q [DEPTH];
  logic [VAL_W-1:0] tbl_val_d [DEPTH];

  logic             ack_q, ack_d;
  logic             hit_q, hit_d;
  logic             dup_q, dup_d;
  logic             err_q, err_d;
  logic             full_q, full_d;
  logic [KEY_W-1:0] kout_q, kout_d;
  logic [VAL_W-1:0] vout_q, vout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             entry_match;

  // Reverse lookup compares the stored value; every other op compares the key.
  always_comb begin
    entry_match = 1'b0;
    if (tbl_vld_q[idx_q]) begin
      if (op_q == 2'd1) entry_match = (tbl_val_q[idx_q] == val_q);
      else              entry_match = (tbl_key_q[idx_q] == key_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    key_d     = key_q;
    val_d     = val_q;
    idx_d     = idx_q;
    mfound_d  = mfound_q;
    ffound_d  = ffound_q;
    midx_d    = midx_q;
    fidx_d    = fidx_q;
    tbl_vld_d = tbl_vld_q;
    tbl_key_d = tbl_key_q;
    tbl_val_d = tbl_val_q;
    ack_d     = 1'b0;
    hit_d     = hit_q;
    dup_d     = dup_q;
    err_d     = err_q;
    kout_d    = kout_q;
    vout_d    = vout_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (CYC_i && STB_i) begin
          state_d  = S_SCAN;
          op_d     = OP_i;
          key_d    = KEY_i;
          val_d    = VAL_i;
          idx_d    = '0;
          mfound_d = 1'b0;
          ffound_d = 1'b0;
          midx_d   = '0;
          fidx_d   = '0;
        end
      end

      S_SCAN: begin
        if (!CYC_i) begin
          state_d = S_IDLE;
        end else begin
          // Only the first hit / first hole is kept, so the lowest index wins.
          if (entry_match && !mfound_q) begin
            mfound_d = 1'b1;
            midx_d   = idx_q;
          end
          if (!tbl_vld_q[idx_q] && !ffound_q) begin
            ffound_d = 1'b1;
            fidx_d   = idx_q;
          end
          if (idx_q == IW'(DEPTH - 1)) state_d = S_RESP;
          else                         idx_d   = idx_q + IW'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        ack_d   = 1'b1;
        hit_d   = 1'b0;
        dup_d   = 1'b0;
        err_d   = 1'b0;
        kout_d  = '0;
        vout_d  = '0;
        case (op_q)
          2'd0, 2'd1: begin
            if (mfound_q) begin
              hit_d  = 1'b1;
              kout_d = tbl_key_q[midx_q];
              vout_d = tbl_val_q[midx_q];
            end
          end
          2'd2: begin
            if (mfound_q) begin
              tbl_val_d[midx_q] = val_q;
              hit_d  = 1'b1;
              dup_d  = 1'b1;
              kout_d = key_q;
              vout_d = val_q;
            end else if (ffound_q) begin
              tbl_vld_d[fidx_q] = 1'b1;
              tbl_key_d[fidx_q] = key_q;
              tbl_val_d[fidx_q] = val_q;
              kout_d = key_q;
              vout_d = val_q;
              cnt_d  = cnt_q + CW'(1);
            end else begin
              err_d = 1'b1;
            end
          end
          default: begin
            if (mfound_q) begin
              tbl_vld_d[midx_q] = 1'b0;
              hit_d  = 1'b1;
              kout_d = tbl_key_q[midx_q];
              vout_d = tbl_val_q[midx_q];
              cnt_d  = cnt_q - CW'(1);
            end
          end
        endcase
      end

      default: state_d = S_IDLE;
    endcase

    // FULL is registered from the next count so it moves together with COUNT_o.
    full_d = (cnt_d == CW'(DEPTH));
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      key_q    <= '0;
      val_q    <= '0;
      idx_q    <= '0;
      mfound_q <= 1'b0;
      ffound_q <= 1'b0;
      midx_q   <= '0;
      fidx_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_vld_q[i] <= 1'b0;
        tbl_key_q[i] <= '0;
        tbl_val_q[i] <= '0;
      end
      ack_q    <= 1'b0;
      hit_q    <= 1'b0;
      dup_q    <= 1'b0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
      kout_q   <= '0;
      vout_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      key_q     <= key_d;
      val_q     <= val_d;
      idx_q     <= idx_d;
      mfound_q  <= mfound_d;
      ffound_q  <= ffound_d;
      midx_q    <= midx_d;
      fidx_q    <= fidx_d;
      tbl_vld_q <= tbl_vld_d;
      tbl_key_q <= tbl_key_d;
      tbl_val_q <= tbl_val_d;
      ack_q     <= ack_d;
      hit_q     <= hit_d;
      dup_q     <= dup_d;
      err_q     <= err_d;
      full_q    <= full_d;
      kout_q    <= kout_d;
      vout_q    <= vout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ACK_o   = ack_q;
  assign STALL_o = (state_q != S_IDLE);
  assign HIT_o   = hit_q;
  assign DUP_o   = dup_q;
  assign ERR_o   = err_q;
  assign FULL_o  = full_q;
  assign KEY_o   = kout_q;
  assign VAL_o   = vout_q;
  assign COUNT_o = cnt_q;

endmodule

// File: tb/tb_kv_store.sv
// Self-checking bench for kv_store: directed scenarios plus randomized
// operations compared against a slot-array reference model.
module tb_kv_store;
  localparam int KW    = 7;
  localparam int VW    = 7;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb;
  logic [1:0]    op;
  logic [KW-1:0] key;
  logic [VW-1:0] val;
  logic          ack, stall, hit, dup, full, err;
  logic [KW-1:0] ko;
  logic [VW-1:0] vo;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  kv_store #(.KEY_W(KW), .VAL_W(VW), .DEPTH(DEPTH)) dut (
    .sys_clk(clk), .sys_rst(rst), .CYC_i(cyc), .STB_i(stb), .OP_i(op),
    .KEY_i(key), .VAL_i(val), .ACK_o(ack), .STALL_o(stall), .HIT_o(hit),
    .DUP_o(dup), .FULL_o(full), .ERR_o(err), .KEY_o(ko), .VAL_o(vo),
    .COUNT_o(cnt)
  );

  typedef struct packed {
    logic          hit;
    logic          dup;
    logic          err;
    logic [KW-1:0] k;
    logic [VW-1:0] v;
    logic [CW-1:0] cnt;
    logic          full;
  } resp_t;

  int checks = 0;
  int errors = 0;

  // Reference model: slot array, lowest index wins for match and free slot.
  logic          m_v   [DEPTH];
  logic [KW-1:0] m_k   [DEPTH];
  logic [VW-1:0] m_val [DEPTH];

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_v[i]) n++;
    return n;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 1'b0; m_k[i] = '0; m_val[i] = '0;
    end
  endfunction

  function automatic resp_t model_op(input logic [1:0] o, input logic [KW-1:0] k,
                                     input logic [VW-1:0] v);
    resp_t r;
    int mi = -1;
    int fi = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (mi < 0 && m_v[i] && ((o == 2'd1) ? (m_val[i] == v) : (m_k[i] == k))) mi = i;
      if (fi < 0 && !m_v[i]) fi = i;
    end
    r = '0;
    if (o <= 2'd1) begin
      if (mi >= 0) begin r.hit = 1; r.k = m_k[mi]; r.v = m_val[mi]; end
    end else if (o == 2'd2) begin
      if (mi >= 0) begin
        m_val[mi] = v; r.hit = 1; r.dup = 1; r.k = k; r.v = v;
      end else if (fi >= 0) begin
        m_v[fi] = 1; m_k[fi] = k; m_val[fi] = v; r.k = k; r.v = v;
      end else r.err = 1;
    end else begin
      if (mi >= 0) begin
        r.hit = 1; r.k = m_k[mi]; r.v = m_val[mi]; m_v[mi] = 0;
      end
    end
    r.cnt  = CW'(m_count());
    r.full = (m_count() == DEPTH);
    return r;
  endfunction

  function automatic resp_t snap();
    resp_t r;
    r.hit = hit; r.dup = dup; r.err = err; r.k = ko; r.v = vo;
    r.cnt = cnt; r.full = full;
    return r;
  endfunction

  // Drives one request, scrambles inputs during the scan, returns the
  // registered response, the accept-to-ACK latency and {ACK,STALL} just
  // after the accept edge.
  task automatic run_op(input logic [1:0] o, input logic [KW-1:0] k,
                        input logic [VW-1:0] v, output resp_t r,
                        output int lat, output logic [1:0] acc);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; op = o; key = k; val = v;
    @(posedge clk); #1;
    acc = {ack, stall};
    stb = 1'b0; op = 2'($urandom); key = KW'($urandom); val = VW'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ack && lat < 40);
    r = snap();
    cyc = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = 0; stb = 0; op = 0; key = 0; val = 0;
    m_clear();
    repeat (2) @(negedge clk);
    checks++;
    if ({ack, stall, snap()} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0", {ack, stall, snap()});
    end
    rst = 1'b0;
  endtask

  task automatic test_insert_lookup();
    logic [1:0]    ops [5] = '{2'd2, 2'd0, 2'd2, 2'd1, 2'd1};
    logic [KW-1:0] ks  [5] = '{7'd5, 7'd5, 7'd5, 7'd0, 7'd0};
    logic [VW-1:0] vs  [5] = '{7'd9, 7'd0, 7'd3, 7'd3, 7'd9};
    resp_t r, e; int lat; logic [1:0] acc;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], ks[i], vs[i], r, lat, acc);
      e = model_op(ops[i], ks[i], vs[i]);
      checks++;
      if (r !== e) begin
        errors++; $display("FAIL ins_lkp[%0d]: got %h required %h", i, r, e);
      end
      checks++;
      if (lat != DEPTH + 1) begin
        errors++; $display("FAIL ins_lkp_latency[%0d]: got %0d required %0d", i, lat, DEPTH + 1);
      end
      if (i == 0) begin
        checks++;
        if (r !== resp_t'{1'b0, 1'b0, 1'b0, 7'd5, 7'd9, 4'd1, 1'b0}) begin
          errors++; $display("FAIL first_insert: got %h required 00005/9/cnt1", r);
        end
      end
    end
  endtask

  task automatic test_full();
    resp_t r, e; int lat; logic [1:0] acc;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      logic [KW-1:0] k;
      logic [VW-1:0] v;
      k = (i <= DEPTH) ? KW'(i) : ((i == DEPTH + 1) ? 7'd20 : 7'd3);
      v = (i <= DEPTH) ? VW'(i * 3) : ((i == DEPTH + 1) ? 7'd1 : 7'd0);
      run_op(2'd2, k, v, r, lat, acc);
      e = model_op(2'd2, k, v);
      checks++;
      if (r !== e) begin
        errors++; $display("FAIL fill[%0d]: got %h required %h", i, r, e);
      end
      if (i == DEPTH) begin
        checks++;
        if ({full, cnt} !== {1'b1, CW'(DEPTH)}) begin
          errors++; $display("FAIL full_flag: got full=%0b cnt=%0d required 1/%0d", full, cnt, DEPTH);
        end
      end
      if (i == DEPTH + 1) begin
        checks++;
        if (err !== 1'b1) begin
          errors++; $display("FAIL insert_when_full_err: got %0b required 1", err);
        end
      end
    end
  endtask

  task automatic test_delete();
    logic [1:0]    ops [4] = '{2'd3, 2'd2, 2'd0, 2'd3};
    logic [KW-1:0] ks  [4] = '{7'd3, 7'd20, 7'd20, 7'd99};
    logic [VW-1:0] vs  [4] = '{7'd0, 7'd17, 7'd0, 7'd0};
    resp_t r, e; int lat; logic [1:0] acc;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], ks[i], vs[i], r, lat, acc);
      e = model_op(ops[i], ks[i], vs[i]);
      checks++;
      if (r !== e) begin
        errors++; $display("FAIL delete_seq[%0d]: got %h required %h", i, r, e);
      end
      if (i == 0) begin
        checks++;
        if ({hit, full, cnt} !== {1'b1, 1'b0, CW'(DEPTH - 1)}) begin
          errors++; $display("FAIL delete_count: got hit=%0b full=%0b cnt=%0d", hit, full, cnt);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    resp_t r, e; int lat; logic [1:0] acc;
    logic [1:0] o; logic [KW-1:0] k; logic [VW-1:0] v;
    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom); k = KW'($urandom_range(0, 24)); v = VW'($urandom_range(0, 8));
      run_op(o, k, v, r, lat, acc);
      e = model_op(o, k, v);
      checks++;
      if (acc !== 2'b01 || lat != DEPTH + 1) begin
        errors++; $display("FAIL b2b_timing[%0d]: got ack/stall=%b lat=%0d required 01/%0d", i, acc, lat, DEPTH + 1);
      end
      checks++;
      if (r !== e) begin
        errors++; $display("FAIL b2b_resp[%0d]: got %h required %h", i, r, e);
      end
    end
  endtask

  task automatic test_abort();
    int acks = 0;
    resp_t r, e; int lat; logic [1:0] acc;
    @(negedge clk);
    cyc = 1; stb = 1; op = 2'd2; key = 7'd30; val = 7'd4;
    @(posedge clk); #1 stb = 0;
    repeat (3) @(posedge clk);
    #1 cyc = 0;
    @(posedge clk); #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL abort_stall: got %0b required 0", stall);
    end
    repeat (12) begin @(posedge clk); #1; if (ack) acks++; end
    checks++;
    if (acks != 0 || cnt !== CW'(m_count())) begin
      errors++; $display("FAIL abort_noack: got acks=%0d cnt=%0d required 0/%0d", acks, cnt, m_count());
    end
    run_op(2'd0, 7'd30, 7'd0, r, lat, acc);
    e = model_op(2'd0, 7'd30, 7'd0);
    checks++;
    if (r !== e) begin
      errors++; $display("FAIL abort_lookup: got %h required %h", r, e);
    end
  endtask

  task automatic test_random();
    resp_t r, e; int lat; logic [1:0] acc;
    logic [1:0] o; logic [KW-1:0] k; logic [VW-1:0] v;
    for (int i = 0; i < 120; i++) begin
      o = 2'($urandom); k = KW'($urandom_range(0, 11)); v = VW'($urandom_range(0, 7));
      run_op(o, k, v, r, lat, acc);
      e = model_op(o, k, v);
      checks++;
      if (r !== e || lat != DEPTH + 1) begin
        errors++; $display("FAIL random[%0d] op%0d k%0d v%0d: got %h lat %0d required %h", i, o, k, v, r, lat, e);
      end
      checks++;
      if (cnt > CW'(DEPTH)) begin
        errors++; $display("FAIL count_range[%0d]: got %0d required <=%0d", i, cnt, DEPTH);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [KW-1:0] prior [$];
    resp_t r, e; int lat; logic [1:0] acc;
    for (int i = 0; i < DEPTH; i++) if (m_v[i]) prior.push_back(m_k[i]);
    if (prior.size() == 0) begin
      run_op(2'd2, 7'd44, 7'd2, r, lat, acc);
      e = model_op(2'd2, 7'd44, 7'd2);
      prior.push_back(7'd44);
    end
    run_op(2'd0, prior[0], 7'd0, r, lat, acc);
    e = model_op(2'd0, prior[0], 7'd0);
    @(negedge clk);
    cyc = 1; stb = 1; op = 2'd0; key = prior[0]; val = 0;
    @(posedge clk); #1 stb = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ack, stall, snap()} !== '0) begin
      errors++; $display("FAIL async_reset: got %h required 0", {ack, stall, snap()});
    end
    @(negedge clk); cyc = 0;
    @(negedge clk); rst = 1'b0;
    m_clear();
    foreach (prior[i]) begin
      run_op(2'd0, prior[i], 7'd0, r, lat, acc);
      e = model_op(2'd0, prior[i], 7'd0);
      checks++;
      if (r !== e || hit !== 1'b0) begin
        errors++; $display("FAIL post_reset_lookup[%0d]: got %h required %h", i, r, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_insert_lookup();
    test_full();
    test_delete();
    test_back_to_back();
    test_abort();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
